// File: rtl/i2s_sample_buffer_pkg.sv
// Shared constants and state types for the I2S sample buffer and its FIFO.
// Memory words carry the channel flag in bit 31 and the sample in bits 23:0.
package i2s_sample_buffer_pkg;

    localparam int I2S_WORD_WIDTH        = 32;
    localparam int I2S_WORD_LR_BIT       = 31;
    localparam int I2S_SAMPLE_WIDTH      = 24;
    localparam int DEFAULT_DEPTH_LOG2    = 7;
    localparam int DEFAULT_REQUEST_WORDS = 64;
    localparam int DEFAULT_LOW_WATER     = 32;

    typedef enum logic {
        FETCH_IDLE,
        FETCH_ACTIVE
    } fetch_state_t;

    typedef enum logic {
        SERVE,
        WAIT_DROP
    } serve_state_t;

    function automatic logic [I2S_SAMPLE_WIDTH-1:0] word_sample(
        input logic [I2S_WORD_WIDTH-1:0] word
    );
        return word[I2S_SAMPLE_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/i2s_sync_fifo.sv
// Single-clock FIFO over an inferred RAM with a registered read port.
// rdata updates only on a successful pop and otherwise holds its last value.
module i2s_sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic [WIDTH-1:0]      rdata_reg;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count_reg == FULL_COUNT);
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            rdata_reg  <= '0;
        end else if (flush) begin
            // Read data is deliberately kept so the last sample stays on the bus.
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                rdata_reg  <= mem[rd_ptr_reg];
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rdata = rdata_reg;
    assign count = count_reg;

endmodule

// File: rtl/i2s_sample_buffer.sv
// Buffers 32-bit memory words for the I2S serializer: fetches bursts when the
// FIFO runs low and hands out one 24-bit sample plus L/R flag per request.
module i2s_sample_buffer
    import i2s_sample_buffer_pkg::*;
#(
    parameter int DEPTH_LOG2    = DEFAULT_DEPTH_LOG2,
    parameter int REQUEST_WORDS = DEFAULT_REQUEST_WORDS,
    parameter int LOW_WATER     = DEFAULT_LOW_WATER
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    output logic                        request_data,
    output logic [23:0]                 request_size,
    input  logic                        request_finished,
    input  logic [31:0]                 memory_data,
    input  logic                        memory_data_strobe,
    input  logic                        audio_data_request,
    output logic                        audio_data_ack,
    output logic [23:0]                 audio_data,
    output logic                        audio_lr_bit,
    output logic                        starved,
    output logic                        overflow,
    output logic [DEPTH_LOG2:0]         fill_level
);

    localparam logic [DEPTH_LOG2:0] FULL_COUNT     = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] LOW_WATER_CNT  = (DEPTH_LOG2+1)'(LOW_WATER);
    localparam logic [DEPTH_LOG2:0] REQUEST_CNT    = (DEPTH_LOG2+1)'(REQUEST_WORDS);
    localparam logic [23:0]         REQUEST_SIZE   = 24'(REQUEST_WORDS);

    fetch_state_t fetch_state_reg;
    serve_state_t serve_state_reg;
    logic         request_data_reg;
    logic [23:0]  request_size_reg;
    logic         ack_reg;
    logic         starved_reg;
    logic         overflow_reg;

    logic [I2S_WORD_WIDTH-1:0] fifo_rdata;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [DEPTH_LOG2:0]       fifo_count;
    logic [DEPTH_LOG2:0]       free_space;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fetch_start;
    logic                      unused_word_bits;

    assign fifo_push   = memory_data_strobe && enable;
    assign fifo_pop    = enable && (serve_state_reg == SERVE) && audio_data_request && !fifo_empty;
    assign free_space  = FULL_COUNT - fifo_count;
    assign fetch_start = enable && (fifo_count <= LOW_WATER_CNT) && (free_space >= REQUEST_CNT);

    i2s_sync_fifo #(
        .WIDTH      (I2S_WORD_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (!enable),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (memory_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst || !enable) begin
            fetch_state_reg  <= FETCH_IDLE;
            request_data_reg <= 1'b0;
            request_size_reg <= '0;
        end else begin
            case (fetch_state_reg)
                FETCH_IDLE: begin
                    if (fetch_start) begin
                        fetch_state_reg  <= FETCH_ACTIVE;
                        request_data_reg <= 1'b1;
                        request_size_reg <= REQUEST_SIZE;
                    end
                end
                FETCH_ACTIVE: begin
                    if (request_finished) begin
                        fetch_state_reg  <= FETCH_IDLE;
                        request_data_reg <= 1'b0;
                        request_size_reg <= '0;
                    end
                end
                default: fetch_state_reg <= FETCH_IDLE;
            endcase
        end
    end

    // The ack lines up with the FIFO's registered read, one cycle after the pop.
    always_ff @(posedge clk) begin
        if (!rst || !enable) begin
            serve_state_reg <= SERVE;
            ack_reg         <= 1'b0;
            starved_reg     <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            ack_reg <= fifo_pop;
            if (memory_data_strobe && fifo_full) begin
                overflow_reg <= 1'b1;
            end
            case (serve_state_reg)
                SERVE: begin
                    if (audio_data_request) begin
                        if (!fifo_empty) begin
                            serve_state_reg <= WAIT_DROP;
                            starved_reg     <= 1'b0;
                        end else begin
                            starved_reg <= 1'b1;
                        end
                    end
                end
                WAIT_DROP: begin
                    if (!audio_data_request) begin
                        serve_state_reg <= SERVE;
                    end
                end
                default: serve_state_reg <= SERVE;
            endcase
        end
    end

    assign unused_word_bits = ^fifo_rdata[I2S_WORD_LR_BIT-1:I2S_SAMPLE_WIDTH];

    assign request_data   = request_data_reg;
    assign request_size   = request_size_reg;
    assign audio_data_ack = ack_reg;
    assign audio_data     = word_sample(fifo_rdata);
    assign audio_lr_bit   = fifo_rdata[I2S_WORD_LR_BIT];
    assign starved        = starved_reg;
    assign overflow       = overflow_reg;
    assign fill_level     = fifo_count;

endmodule

// File: tb/tb_i2s_sample_buffer.sv
// Directed bench for i2s_sample_buffer: stimulus queues expected words, a
// separate monitor checks every ack against the queue head.
module tb_i2s_sample_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        request_data;
    logic [23:0] request_size;
    logic        request_finished;
    logic [31:0] memory_data;
    logic        memory_data_strobe;
    logic        audio_data_request;
    logic        audio_data_ack;
    logic [23:0] audio_data;
    logic        audio_lr_bit;
    logic        starved;
    logic        overflow;
    logic [7:0]  fill_level;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    i2s_sample_buffer dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .request_data       (request_data),
        .request_size       (request_size),
        .request_finished   (request_finished),
        .memory_data        (memory_data),
        .memory_data_strobe (memory_data_strobe),
        .audio_data_request (audio_data_request),
        .audio_data_ack     (audio_data_ack),
        .audio_data         (audio_data),
        .audio_lr_bit       (audio_lr_bit),
        .starved            (starved),
        .overflow           (overflow),
        .fill_level         (fill_level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_word(input int i);
        logic [31:0] w;
        if (i == 0) w = 32'h8012_3456;
        else        w = {i[0], 7'h55, 24'hA0_0000 + 24'(i)};
        return w;
    endfunction

    // Expected FIFO contents: a strobed word is kept only when there is room.
    task automatic strobe(input logic [31:0] w);
        memory_data        = w;
        memory_data_strobe = 1'b1;
        if (enable && exp_q.size() < 128) exp_q.push_back(w);
        tick;
        memory_data_strobe = 1'b0;
    endtask

    task automatic serve_one;
        bit got;
        got = 1'b0;
        audio_data_request = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            tick;
            if (audio_data_ack) got = 1'b1;
        end
        check("serve_ack_seen", 32'(got), 32'd1);
        audio_data_request = 1'b0;
        tick;
    endtask

    always @(negedge clk) begin
        logic [31:0] w;
        if (rst === 1'b1 && audio_data_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got sample 0x%06h required no ack", audio_data);
            end else begin
                w = exp_q.pop_front();
                $display("ack sample=0x%06h lr=%0d expected sample=0x%06h lr=%0d",
                         audio_data, audio_lr_bit, w[23:0], w[31]);
                check("ack_sample", 32'(audio_data), 32'(w[23:0]));
                check("ack_lr", 32'(audio_lr_bit), 32'(w[31]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        int first_ack;

        rst = 1'b0;
        enable = 1'b1;
        request_finished = 1'b0;
        memory_data = '0;
        memory_data_strobe = 1'b0;
        audio_data_request = 1'b0;

        // 1: reset state, then a request right after release
        repeat (3) tick;
        check("rst_request_data", 32'(request_data), 32'd0);
        check("rst_request_size", 32'(request_size), 32'd0);
        check("rst_ack", 32'(audio_data_ack), 32'd0);
        check("rst_audio_data", 32'(audio_data), 32'd0);
        check("rst_lr", 32'(audio_lr_bit), 32'd0);
        check("rst_starved", 32'(starved), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        rst = 1'b1;
        tick;
        check("first_request_data", 32'(request_data), 32'd1);
        check("first_request_size", 32'(request_size), 32'd64);

        // 2: one full burst ends the request; 64 words is above low water
        for (int i = 0; i < 64; i++) strobe(mk_word(i));
        request_finished = 1'b1;
        tick;
        request_finished = 1'b0;
        check("burst_fill", 32'(fill_level), 32'd64);
        check("burst_request_dropped", 32'(request_data), 32'd0);
        repeat (3) tick;
        check("no_new_request", 32'(request_data), 32'd0);

        // 3: level request held 5 cycles gives exactly one ack after 1 cycle
        audio_data_request = 1'b1;
        acks = 0;
        first_ack = -1;
        for (int c = 1; c <= 5; c++) begin
            tick;
            if (audio_data_ack) begin
                acks++;
                if (first_ack < 0) first_ack = c;
            end
        end
        audio_data_request = 1'b0;
        tick;
        check("held_request_acks", 32'(acks), 32'd1);
        check("ack_latency", 32'(first_ack), 32'd1);
        check("fill_after_pop", 32'(fill_level), 32'd63);

        // 4: low-water boundary while draining, starvation, then recovery
        repeat (30) serve_one;
        check("fill_33", 32'(fill_level), 32'd33);
        check("no_request_at_33", 32'(request_data), 32'd0);
        serve_one;
        check("request_at_32", 32'(request_data), 32'd1);
        repeat (32) serve_one;
        check("drained_fill", 32'(fill_level), 32'd0);
        check("not_starved_yet", 32'(starved), 32'd0);
        audio_data_request = 1'b1;
        tick;
        check("starved_set", 32'(starved), 32'd1);
        memory_data = 32'h00AB_CDEF;
        memory_data_strobe = 1'b1;
        exp_q.push_back(32'h00AB_CDEF);
        tick;
        memory_data_strobe = 1'b0;
        check("no_fallthrough_ack", 32'(audio_data_ack), 32'd0);
        tick;
        check("recover_ack", 32'(audio_data_ack), 32'd1);
        check("starved_cleared", 32'(starved), 32'd0);
        audio_data_request = 1'b0;
        tick;

        // 5: fill to full, one dropped word, sticky overflow, enable pulse clears
        for (int i = 0; i < 128; i++) strobe(mk_word(i + 100));
        check("full_fill", 32'(fill_level), 32'd128);
        check("no_overflow_yet", 32'(overflow), 32'd0);
        strobe(32'hDEAD_BEEF);
        check("overflow_set", 32'(overflow), 32'd1);
        check("fill_stays_full", 32'(fill_level), 32'd128);
        tick;
        check("overflow_sticky", 32'(overflow), 32'd1);
        enable = 1'b0;
        exp_q.delete();
        tick;
        check("flush_fill", 32'(fill_level), 32'd0);
        check("flush_overflow", 32'(overflow), 32'd0);
        check("flush_request", 32'(request_data), 32'd0);
        enable = 1'b1;

        // 6: enable drop in the middle of a burst, then a fresh request
        tick;
        check("reenable_request", 32'(request_data), 32'd1);
        check("reenable_size", 32'(request_size), 32'd64);
        for (int i = 0; i < 10; i++) strobe(mk_word(i + 300));
        check("partial_fill", 32'(fill_level), 32'd10);
        enable = 1'b0;
        exp_q.delete();
        tick;
        check("midfetch_request_off", 32'(request_data), 32'd0);
        check("midfetch_flush", 32'(fill_level), 32'd0);
        enable = 1'b1;
        tick;
        check("fresh_request", 32'(request_data), 32'd1);
        check("fresh_size", 32'(request_size), 32'd64);
        strobe(32'h00C0_FFEE);
        serve_one;
        check("final_fill", 32'(fill_level), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
